gpio_in_debounce: RTL

Input conditioning stage directly upstream of the AHB GPIO peripheral. It synchronises 16 raw asynchronous pins into HCLK, debounces each bit independently, and drives the 17-bit GPIOIN bus: 16 data bits plus a parity bit in bit 16. The parity bit is generated according to PARITYSEL, so the GPIO's parity checker sees a consistent word. It also provides per-bit change pulses for interrupt/edge logic.

---
 rtl/gpio_in_debounce.sv | 113 +++++++++++
 1 files changed

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
//   Input conditioning in front of the AHB GPIO block. It has three jobs:
//     - bring WIDTH raw async pins into HCLK through a two-flop synchroniser;
//     - debounce each bit independently with a saturating-free mismatch counter;
//     - publish the debounced word plus a parity bit, so that the downstream
//       parity checker never sees a data/parity mismatch.
//
// Ports
//   HCLK      in   1        system clock, rising edge
//   HRESETn   in   1        synchronous reset, ACTIVE HIGH (despite the name)
//   PIN_IN    in   WIDTH    raw asynchronous pin levels
//   PARITYSEL in   1        0 = even parity, 1 = odd parity (HCLK domain)
//   GPIOIN    out  WIDTH+1  [WIDTH-1:0] debounced data, [WIDTH] parity; registered
//   CHANGE    out  WIDTH    one-cycle pulse per debounced transition; registered

// Per-bit debouncer. stable follows din only after din has disagreed with it
// for DEBOUNCE_CYCLES consecutive edges.
module gpio_in_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic stable_next,
    output logic change
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             hit;

    always_comb begin
        mismatch    = (din != stable);
        hit         = mismatch && (cnt == CNT_LAST);
        // Exposed so the parity bit can be computed from the value stable is
        // about to take, keeping data and parity in lock-step.
        stable_next = hit ? din : stable;
    end

    // Counter clears on agreement or on the update itself, so it never
    // exceeds CNT_LAST and cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            change <= 1'b0;
        end else begin
            stable <= stable_next;
            change <= hit;
            if (!mismatch || hit) cnt <= '0;
            else                  cnt <= cnt + 1'b1;
        end
    end
endmodule

module gpio_in_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] PIN_IN,
    input  logic             PARITYSEL,
    output logic [WIDTH:0]   GPIOIN,
    output logic [WIDTH-1:0] CHANGE
);
    // Derived from DEBOUNCE_CYCLES; a localparam so it cannot be overridden
    // out of step with the debounce length.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic             parity_q;

    // Plain two-flop synchroniser, nothing between the stages.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= PIN_IN;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_in_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_lane (
            .clk         (HCLK),
            .rst         (HRESETn),
            .din         (sync2[i]),
            .stable      (stable[i]),
            .stable_next (stable_next[i]),
            .change      (CHANGE[i])
        );
    end

    // Parity is registered from stable_next rather than stable so it lands on
    // the same edge as the data it covers.
    always_ff @(posedge HCLK) begin
        if (HRESETn) parity_q <= 1'b0;
        else         parity_q <= (^stable_next) ^ PARITYSEL;
    end

    assign GPIOIN = {parity_q, stable};
endmodule
